// File: rtl/vga_rx_monitor_if.sv
// Sample-side bundle of the VGA receive monitor: sync/rgb/control in, grid/checksum/status out.
interface vga_rx_monitor_if;
  logic        p_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        err_clear;
  logic        locked;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] pixel_rgb;
  logic        frame_done;
  logic [31:0] frame_sum;
  logic        err_hsync;
  logic        err_line;
  logic        err_frame;

  modport master (
    output p_tick, hsync, vsync, rgb, err_clear,
    input  locked, pixel_valid, pixel_x, pixel_y, pixel_rgb,
           frame_done, frame_sum, err_hsync, err_line, err_frame
  );

  modport slave (
    input  p_tick, hsync, vsync, rgb, err_clear,
    output locked, pixel_valid, pixel_x, pixel_y, pixel_rgb,
           frame_done, frame_sum, err_hsync, err_line, err_frame
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA sink: recovers the pixel grid from hsync/vsync, verifies timing, locks,
// and produces a per-frame wrap-around rgb checksum.
module vga_rx_monitor #(
  parameter int H_SYNC    = 96,
  parameter int H_TOTAL   = 800,
  parameter int V_SYNC    = 2,
  parameter int V_TOTAL   = 525,
  parameter int H_START   = 144,
  parameter int V_START   = 35,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter bit SYNC_POL  = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  vga_rx_monitor_if.slave vif
);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
  localparam logic [10:0] H_SYN_L = 11'(H_SYNC);
  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_DISPLAY);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_DISPLAY);
  localparam logic [11:0] V_TOT_L = 12'(V_TOTAL);
  localparam logic [9:0]  V_SYN_L = 10'(V_SYNC);

  state_t      state_q, state_d;
  logic        hs_prev, vs_prev, frame_err_q;
  logic [9:0]  hcnt_q, vline_q, vw_q, h_cur, v_cur;
  logic [10:0] lcnt_q;
  logic [31:0] acc_q;
  logic        pv_q, done_q, eh_q, el_q, ef_q;
  logic [9:0]  px_q, py_q;
  logic [11:0] prgb_q;
  logic [31:0] fsum_q;

  logic hs_a, vs_a, hs_edge, hs_fall, vs_edge, vs_fall;
  logic line_bad, hsw_bad, frame_bad, any_bad, chk_en, pv_cur, done_d;
  logic [11:0] lines_total;

  assign hs_a    = (vif.hsync == SYNC_POL);
  assign vs_a    = (vif.vsync == SYNC_POL);
  assign hs_edge = hs_a & ~hs_prev;
  assign hs_fall = ~hs_a & hs_prev;
  assign vs_edge = vs_a & ~vs_prev;
  assign vs_fall = ~vs_a & vs_prev;

  // Index of the sample being presented now; the registers hold the previous one.
  always_comb begin
    h_cur = hcnt_q;
    if (hs_edge) h_cur = '0;
    else if (hcnt_q != 10'h3FF) h_cur = hcnt_q + 10'd1;
    v_cur = vline_q;
    if (vs_edge) v_cur = '0;
    else if (hs_edge && vline_q != 10'h3FF) v_cur = vline_q + 10'd1;
  end

  // A coincident hsync edge is the last line of the frame that is ending.
  assign lines_total = {1'b0, lcnt_q} + {11'd0, hs_edge};
  assign line_bad    = hs_edge && ({1'b0, hcnt_q} + 11'd1 != H_TOT_L);
  assign hsw_bad     = hs_fall && ({1'b0, hcnt_q} + 11'd1 != H_SYN_L);
  assign frame_bad   = (vs_edge && lines_total != V_TOT_L) || (vs_fall && vw_q != V_SYN_L);
  assign any_bad     = line_bad | hsw_bad | frame_bad;
  assign chk_en      = (state_q != SEARCH);
  assign pv_cur      = (state_q == LOCKED) &&
                       {1'b0, h_cur} >= H_LO && {1'b0, h_cur} < H_HI &&
                       {1'b0, v_cur} >= V_LO && {1'b0, v_cur} < V_HI;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (vif.p_tick) begin
      unique case (state_q)
        SEARCH: if (vs_edge) state_d = ALIGN;
        ALIGN:  if (vs_edge && !frame_err_q && !any_bad) state_d = LOCKED;
        LOCKED: begin
          if (any_bad)      state_d = SEARCH;
          else if (vs_edge) done_d  = 1'b1;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEARCH;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev <= 1'b0; vs_prev <= 1'b0; frame_err_q <= 1'b0;
      hcnt_q  <= '0;   vline_q <= '0;   vw_q <= '0; lcnt_q <= '0;
      acc_q   <= '0;   fsum_q  <= '0;   done_q <= 1'b0;
      pv_q    <= 1'b0; px_q    <= '0;   py_q <= '0; prgb_q <= '0;
      eh_q    <= 1'b0; el_q    <= 1'b0; ef_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (done_d) fsum_q <= acc_q;
      if (vif.p_tick) begin
        hs_prev <= hs_a;
        vs_prev <= vs_a;
        hcnt_q  <= h_cur;
        vline_q <= v_cur;
        if (vs_edge)                           lcnt_q <= '0;
        else if (hs_edge && lcnt_q != 11'h7FF) lcnt_q <= lcnt_q + 11'd1;
        if (vs_edge)                                 vw_q <= {9'd0, hs_edge};
        else if (vs_a && hs_edge && vw_q != 10'h3FF) vw_q <= vw_q + 10'd1;
        if (vs_edge)      frame_err_q <= 1'b0;
        else if (any_bad) frame_err_q <= 1'b1;
        // A lost lock throws away whatever was summed of the broken frame.
        if (vs_edge || (state_q == LOCKED && any_bad)) acc_q <= '0;
        else if (pv_cur) acc_q <= acc_q + {20'd0, vif.rgb};
        pv_q   <= pv_cur;
        px_q   <= pv_cur ? 10'({1'b0, h_cur} - H_LO) : '0;
        py_q   <= pv_cur ? 10'({1'b0, v_cur} - V_LO) : '0;
        prgb_q <= pv_cur ? vif.rgb : '0;
        // New error beats a simultaneous clear.
        if (chk_en && hsw_bad)        eh_q <= 1'b1;
        else if (vif.err_clear)       eh_q <= 1'b0;
        if (chk_en && line_bad)       el_q <= 1'b1;
        else if (vif.err_clear)       el_q <= 1'b0;
        if (chk_en && frame_bad)      ef_q <= 1'b1;
        else if (vif.err_clear)       ef_q <= 1'b0;
      end
    end
  end

  assign vif.locked      = (state_q == LOCKED);
  assign vif.pixel_valid = pv_q;
  assign vif.pixel_x     = px_q;
  assign vif.pixel_y     = py_q;
  assign vif.pixel_rgb   = prgb_q;
  assign vif.frame_done  = done_q;
  assign vif.frame_sum   = fsum_q;
  assign vif.err_hsync   = eh_q;
  assign vif.err_line    = el_q;
  assign vif.err_frame   = ef_q;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed frame-level bench for vga_rx_monitor on a shrunken 10x6 raster
// (20 samples/line, 12 lines/frame) so whole frames fit in a short run.
module tb_vga_rx_monitor;
  localparam int HT = 20, HSY = 4, HST = 6, HD = 10;
  localparam int VT = 12, VSY = 2, VST = 3, VD = 6;
  localparam logic [31:0] SUM = 32'd245700; // 60 pixels * 12'hFFF

  typedef struct {
    int nl, bl, blen, hl, hv, mode, cl, cs;
    bit gap;
    bit lk, eh, el, ef;
    int dn, pv;
    logic [31:0] sm;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vga_rx_monitor_if vif();
  vga_rx_monitor #(
    .H_SYNC(HSY), .H_TOTAL(HT), .V_SYNC(VSY), .V_TOTAL(VT),
    .H_START(HST), .V_START(VST), .H_DISPLAY(HD), .V_DISPLAY(VD), .SYNC_POL(1'b1)
  ) dut (.clk(clk), .reset_n(reset_n), .vif(vif));

  int n_chk = 0, n_bad = 0;

  // Monitor: monotonic counters, read by the main process as deltas.
  int cyc = 0, pv_cnt = 0, done_cnt = 0, nz_cnt = 0, mark = -1;
  int el_rise = -1, lk_fall = -2;
  logic el_prev = 1'b0, lk_prev = 1'b0;
  logic [9:0]  first_x, first_y, last_x, last_y, nz_x, nz_y;
  logic [11:0] nz_rgb;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (vif.pixel_valid) begin
      if (pv_cnt == mark) begin first_x = vif.pixel_x; first_y = vif.pixel_y; end
      last_x = vif.pixel_x; last_y = vif.pixel_y;
      if (vif.pixel_rgb != 12'h0) begin
        nz_cnt++; nz_x = vif.pixel_x; nz_y = vif.pixel_y; nz_rgb = vif.pixel_rgb;
      end
      pv_cnt++;
    end
    if (vif.frame_done) done_cnt++;
    if (vif.err_line && !el_prev) el_rise = cyc;
    if (!vif.locked && lk_prev) lk_fall = cyc;
    el_prev = vif.err_line;
    lk_prev = vif.locked;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".locked"},      32'(vif.locked), 0);
    chk({tag, ".pixel_valid"}, 32'(vif.pixel_valid), 0);
    chk({tag, ".pixel_x"},     32'(vif.pixel_x), 0);
    chk({tag, ".pixel_y"},     32'(vif.pixel_y), 0);
    chk({tag, ".pixel_rgb"},   32'(vif.pixel_rgb), 0);
    chk({tag, ".frame_done"},  32'(vif.frame_done), 0);
    chk({tag, ".frame_sum"},   vif.frame_sum, 0);
    chk({tag, ".err_hsync"},   32'(vif.err_hsync), 0);
    chk({tag, ".err_line"},    32'(vif.err_line), 0);
    chk({tag, ".err_frame"},   32'(vif.err_frame), 0);
  endtask

  function automatic logic [11:0] pix(input int mode, input int l, input int h);
    case (mode)
      1:       return 12'hFFF;
      2:       return (l == VST + VD - 1 && h == HST + HD - 1) ? 12'hA5C : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  // Called at a falling edge; each sample occupies one clock (plus a p_tick-low
  // clock carrying garbage when gap is set).
  task automatic drive_line(input int l, input int len, input int hw, input int mode,
                            input int cs, input bit gap);
    for (int h = 0; h < len; h++) begin
      vif.p_tick = 1'b1; vif.hsync = (h < hw); vif.vsync = (l < VSY);
      vif.rgb = pix(mode, l, h); vif.err_clear = (h == cs);
      @(negedge clk);
      if (gap) begin
        vif.p_tick = 1'b0; vif.hsync = ~vif.hsync; vif.vsync = ~vif.vsync;
        vif.rgb = 12'($urandom); vif.err_clear = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    for (int l = 0; l < v.nl; l++)
      drive_line(l, (l == v.bl) ? v.blen : HT, (l == v.hl) ? v.hv : HSY,
                 v.mode, (l == v.cl) ? v.cs : -1, v.gap);
  endtask

  function automatic vec_t mk(input int nl, bl, blen, hl, hv, mode, cl, cs, input bit gap,
                              input bit lk, eh, el, ef, input int dn, pv, input logic [31:0] sm);
    vec_t v;
    v.nl = nl; v.bl = bl; v.blen = blen; v.hl = hl; v.hv = hv; v.mode = mode;
    v.cl = cl; v.cs = cs; v.gap = gap; v.lk = lk; v.eh = eh; v.el = el; v.ef = ef;
    v.dn = dn; v.pv = pv; v.sm = sm;
    return v;
  endfunction

  vec_t vt[15];

  initial begin
    //            nl  bl blen hl hv mode cl cs gap  lk eh el ef dn  pv  sum
    vt[0]  = mk(12, -1,  0, -1, 0, 0, -1, -1, 0,  0, 0, 0, 0, 0,   0, 0);
    vt[1]  = mk(12, -1,  0, -1, 0, 1, -1, -1, 0,  1, 0, 0, 0, 0,  60, 0);
    vt[2]  = mk(12, -1,  0, -1, 0, 0, -1, -1, 0,  1, 0, 0, 0, 1,  60, SUM);
    vt[3]  = mk(12, -1,  0, -1, 0, 2, -1, -1, 0,  1, 0, 0, 0, 1,  60, 0);
    vt[4]  = mk(12,  5, 21, -1, 0, 0, -1, -1, 0,  0, 0, 1, 0, 1,  30, 32'd2652);
    vt[5]  = mk(12, -1,  0, -1, 0, 0, -1, -1, 0,  0, 0, 1, 0, 0,   0, 32'd2652);
    vt[6]  = mk(12, -1,  0, -1, 0, 1, -1, -1, 0,  1, 0, 1, 0, 0,  60, 32'd2652);
    vt[7]  = mk(12, -1,  0, -1, 0, 0,  1, 10, 0,  1, 0, 0, 0, 1,  60, SUM);
    vt[8]  = mk(11, -1,  0, -1, 0, 1, -1, -1, 0,  1, 0, 0, 0, 1,  60, 0);
    vt[9]  = mk(12, -1,  0, -1, 0, 0, -1, -1, 0,  0, 0, 0, 1, 0,   0, 0);
    vt[10] = mk(12, -1,  0,  4, 3, 0,  4,  3, 0,  0, 1, 0, 0, 0,   0, 0);
    vt[11] = mk(12, -1,  0, -1, 0, 0, -1, -1, 0,  0, 1, 0, 0, 0,   0, 0);
    vt[12] = mk(12, -1,  0, -1, 0, 1, -1, -1, 0,  1, 1, 0, 0, 0,  60, 0);
    vt[13] = mk(12, -1,  0, -1, 0, 1, -1, -1, 1,  1, 1, 0, 0, 1, 120, SUM);
    vt[14] = mk(12, -1,  0, -1, 0, 0, -1, -1, 0,  1, 1, 0, 0, 1,  60, SUM);

    reset_n = 1'b0;
    vif.p_tick = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0; vif.rgb = '0; vif.err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      int pv0, dn0, nz0;
      pv0 = pv_cnt; dn0 = done_cnt; nz0 = nz_cnt; mark = pv_cnt;
      run_frame(vt[i]);
      chk($sformatf("v%0d.locked", i),     32'(vif.locked),    32'(vt[i].lk));
      chk($sformatf("v%0d.err_hsync", i),  32'(vif.err_hsync), 32'(vt[i].eh));
      chk($sformatf("v%0d.err_line", i),   32'(vif.err_line),  32'(vt[i].el));
      chk($sformatf("v%0d.err_frame", i),  32'(vif.err_frame), 32'(vt[i].ef));
      chk($sformatf("v%0d.done_cnt", i),   32'(done_cnt - dn0), 32'(vt[i].dn));
      chk($sformatf("v%0d.pv_cnt", i),     32'(pv_cnt - pv0),   32'(vt[i].pv));
      chk($sformatf("v%0d.frame_sum", i),  vif.frame_sum,       vt[i].sm);
      if (i == 1) begin
        chk("v1.first_x", 32'(first_x), 0);
        chk("v1.first_y", 32'(first_y), 0);
        chk("v1.last_x",  32'(last_x), HD - 1);
        chk("v1.last_y",  32'(last_y), VD - 1);
      end
      if (i == 3) begin
        chk("v3.nz_cnt", 32'(nz_cnt - nz0), 1);
        chk("v3.nz_x",   32'(nz_x), 9);
        chk("v3.nz_y",   32'(nz_y), 5);
        chk("v3.nz_rgb", 32'(nz_rgb), 32'h0A5C);
      end
      if (i == 4) chk("v4.unlock_cycle", 32'(lk_fall), 32'(el_rise));
    end

    // Reset while locked, part-way through a frame.
    for (int l = 0; l < 5; l++) drive_line(l, HT, HSY, 1, -1, 1'b0);
    chk("pre_rst.locked", 32'(vif.locked), 1);
    reset_n = 1'b0; vif.p_tick = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int l = 5; l < VT; l++) drive_line(l, HT, HSY, 0, -1, 1'b0);
    run_frame(mk(12, -1, 0, -1, 0, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("relock_a.locked", 32'(vif.locked), 0);
    begin
      int pv0, dn0;
      pv0 = pv_cnt; dn0 = done_cnt;
      run_frame(mk(12, -1, 0, -1, 0, 1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("relock_b.locked",   32'(vif.locked), 1);
      chk("relock_b.pv_cnt",   32'(pv_cnt - pv0), 60);
      chk("relock_b.done_cnt", 32'(done_cnt - dn0), 0);
      chk("relock_b.errs",     32'({vif.err_hsync, vif.err_line, vif.err_frame}), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
